// File: rtl/logic_unit.sv
// Single-stage bitwise logic unit with valid/ready handshake, optional accumulator
// feedback as the second operand, registered parity/zero flags and an accepted-op counter.
module logic_unit #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [2:0]    op,
    input  logic          acc,
    input  logic          clr_acc,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [N-1:0]  y,
    output logic          parity,
    output logic          zero,
    output logic [CW-1:0] count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The upstream side is ready whenever the output register is empty or being drained.

    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  y_q, y_d;
    logic          parity_q, parity_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;

    logic          accept;
    logic [N-1:0]  operand_b;
    logic [N-1:0]  result;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A same-cycle clear is applied before the accumulator is used as an operand.
    always_comb begin
        operand_b = b;
        if (acc) begin
            operand_b = clr_acc ? '0 : acc_q;
        end
    end

    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = a & operand_b;
            3'b001:  result = a | operand_b;
            3'b010:  result = a ^ operand_b;
            3'b011:  result = ~(a ^ operand_b);
            3'b100:  result = ~(a & operand_b);
            3'b101:  result = ~(a | operand_b);
            3'b110:  result = a & ~operand_b;
            default: result = a;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        parity_d    = parity_q;
        zero_d      = zero_q;
        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = result;
            parity_d    = ^result;
            zero_d      = (result == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_acc) begin
            acc_d = '0;
        end
        if (accept && acc) begin
            acc_d = result;
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            parity_q    <= 1'b0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            parity_q    <= parity_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign parity    = parity_q;
    assign zero      = zero_q;
    assign count     = count_q;

endmodule
